stpmtr_cmdq: RTL and testbench

// - Command queue and issuer sitting directly upstream of the stepper-motor controller (stpmtr).
// - Buffers absolute target positions from the host and range-checks them.
// - Presents one target at a time on the motor's pos/valid/ack handshake.
// - Watches each handshake with a timeout; a hung motor raises a sticky flag.

---
 rtl/stpmtr_pkg.sv | 15 +
 rtl/stpmtr_fifo.sv | 57 +++++
 rtl/stpmtr_cmdq.sv | 135 +++++++++++++
 tb/tb_stpmtr_cmdq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stpmtr_pkg.sv
// Shared types and constants for the stepper-motor command queue.
package stpmtr_pkg;

   localparam int unsigned POS_MAX = 240;

   typedef logic [7:0] pos_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2,
      HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/stpmtr_fifo.sv
// Synchronous FIFO with flush; level is a register, full/empty decode it.
module stpmtr_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned W     = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   lvl_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (lvl_q == (AW+1)'(DEPTH));
   assign empty_o = (lvl_q == '0);
   assign level_o = lvl_q;
   assign dout_o  = mem_q[rd_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   lvl_q <= lvl_q + (AW+1)'(1);
            2'b01:   lvl_q <= lvl_q - (AW+1)'(1);
            default: lvl_q <= lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/stpmtr_cmdq.sv
// Command queue and issuer feeding the stepper-motor pos/valid/ack port,
// with a handshake timeout that parks the in-flight target until cleared.
module stpmtr_cmdq
   import stpmtr_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned TMO   = 511
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  cmd_pos_i,
   input  logic        cmd_we_i,
   input  logic        flush_i,
   input  logic        clr_tmo_i,
   output logic        cmd_full_o,
   output logic        cmd_err_o,
   output logic [AW:0] level_o,
   output logic        busy_o,
   output logic        tmo_o,
   output logic [7:0]  mtr_pos_o,
   output logic        mtr_valid_o,
   input  logic        mtr_ack_i
);

   localparam int unsigned   CW       = $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
   localparam pos_t          POS_LIM  = pos_t'(POS_MAX);

   state_e        state_q, state_d;
   logic          valid_q, valid_d;
   pos_t          pos_q, pos_d;
   logic          tmo_q, tmo_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic fifo_full;
   logic fifo_empty;
   pos_t head;
   logic in_range;
   logic push;
   logic pop;

   assign in_range = (cmd_pos_i <= POS_LIM);
   assign push     = cmd_we_i & ~flush_i & ~fifo_full & in_range;
   assign err_d    = cmd_we_i & ~flush_i & (fifo_full | ~in_range);

   stpmtr_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .din_i   (cmd_pos_i),
      .pop_i   (pop),
      .flush_i (flush_i),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      pos_d   = pos_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !flush_i) begin
               pop     = 1'b1;
               pos_d   = head;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // ack wins over a timeout landing in the same cycle
            if (mtr_ack_i) begin
               valid_d = 1'b0;
               state_d = GAP;
            end else if (cnt_q == TMO_LAST) begin
               valid_d = 1'b0;
               tmo_d   = 1'b1;
               state_d = HALT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         HALT: begin
            if (clr_tmo_i) begin
               tmo_d   = 1'b0;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         pos_q   <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         pos_q   <= pos_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cmd_full_o  = fifo_full;
   assign cmd_err_o   = err_q;
   assign busy_o      = (state_q != IDLE) | ~fifo_empty;
   assign tmo_o       = tmo_q;
   assign mtr_pos_o   = pos_q;
   assign mtr_valid_o = valid_q;

endmodule

// File: tb/tb_stpmtr_cmdq.sv
// Directed bench for stpmtr_cmdq: vector table plus multi-cycle sequences.
module tb_stpmtr_cmdq;

   localparam int TMO = 511;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [7:0] cmd_pos_i = '0;
   logic       cmd_we_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       clr_tmo_i = 1'b0;
   logic       mtr_ack_i = 1'b0;
   logic       cmd_full_o;
   logic       cmd_err_o;
   logic [3:0] level_o;
   logic       busy_o;
   logic       tmo_o;
   logic [7:0] mtr_pos_o;
   logic       mtr_valid_o;

   int errs = 0;
   int checks = 0;

   stpmtr_cmdq #(.DEPTH(8), .AW(3), .TMO(TMO)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cmd_pos_i   (cmd_pos_i),
      .cmd_we_i    (cmd_we_i),
      .flush_i     (flush_i),
      .clr_tmo_i   (clr_tmo_i),
      .cmd_full_o  (cmd_full_o),
      .cmd_err_o   (cmd_err_o),
      .level_o     (level_o),
      .busy_o      (busy_o),
      .tmo_o       (tmo_o),
      .mtr_pos_o   (mtr_pos_o),
      .mtr_valid_o (mtr_valid_o),
      .mtr_ack_i   (mtr_ack_i)
   );

   always #5 clk_i = ~clk_i;

   // packed {valid, pos, level, err, full, busy, tmo}
   typedef struct {
      logic        we;
      logic [7:0]  pos;
      logic        ack;
      logic [16:0] exp;
   } vec_t;

   function automatic logic [16:0] pk(input logic v, input logic [7:0] p,
                                      input logic [3:0] l, input logic e,
                                      input logic f, input logic b,
                                      input logic t);
      return {v, p, l, e, f, b, t};
   endfunction

   function automatic vec_t mk(input logic we, input logic [7:0] pos,
                               input logic ack, input logic [16:0] exp);
      vec_t r;
      r.we = we;
      r.pos = pos;
      r.ack = ack;
      r.exp = exp;
      return r;
   endfunction

   function automatic logic [16:0] act();
      return {mtr_valid_o, mtr_pos_o, level_o, cmd_err_o,
              cmd_full_o, busy_o, tmo_o};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 30 && mtr_valid_o !== 1'b1; i++) step();
      chk(nm, 32'(mtr_valid_o), 32'd1);
   endtask

   task automatic ack_once(input string nm);
      mtr_ack_i = 1'b1;
      step();
      mtr_ack_i = 1'b0;
      chk(nm, 32'(mtr_valid_o), 32'd0);
   endtask

   task automatic wr(input logic [7:0] p);
      cmd_we_i = 1'b1;
      cmd_pos_i = p;
      step();
      cmd_we_i = 1'b0;
   endtask

   vec_t tbl [14];

   initial begin
      tbl[0]  = mk(0, 8'd0,   0, pk(0, 8'd0,   4'd0, 0, 0, 0, 0));
      tbl[1]  = mk(1, 8'd100, 0, pk(0, 8'd0,   4'd1, 0, 0, 1, 0));
      tbl[2]  = mk(0, 8'd0,   0, pk(1, 8'd100, 4'd0, 0, 0, 1, 0));
      tbl[3]  = mk(0, 8'd0,   0, pk(1, 8'd100, 4'd0, 0, 0, 1, 0));
      tbl[4]  = mk(0, 8'd0,   0, pk(1, 8'd100, 4'd0, 0, 0, 1, 0));
      tbl[5]  = mk(0, 8'd0,   0, pk(1, 8'd100, 4'd0, 0, 0, 1, 0));
      tbl[6]  = mk(0, 8'd0,   1, pk(0, 8'd100, 4'd0, 0, 0, 1, 0));
      tbl[7]  = mk(0, 8'd0,   0, pk(0, 8'd100, 4'd0, 0, 0, 0, 0));
      tbl[8]  = mk(1, 8'd241, 0, pk(0, 8'd100, 4'd0, 1, 0, 0, 0));
      tbl[9]  = mk(0, 8'd0,   0, pk(0, 8'd100, 4'd0, 0, 0, 0, 0));
      tbl[10] = mk(1, 8'd240, 0, pk(0, 8'd100, 4'd1, 0, 0, 1, 0));
      tbl[11] = mk(0, 8'd0,   0, pk(1, 8'd240, 4'd0, 0, 0, 1, 0));
      tbl[12] = mk(0, 8'd0,   1, pk(0, 8'd240, 4'd0, 0, 0, 1, 0));
      tbl[13] = mk(0, 8'd0,   0, pk(0, 8'd240, 4'd0, 0, 0, 0, 0));

      #2;
      chk("reset_state", 32'(act()), 32'd0);
      #10;
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < 14; i++) begin
         cmd_we_i = tbl[i].we;
         cmd_pos_i = tbl[i].pos;
         mtr_ack_i = tbl[i].ack;
         step();
         chk($sformatf("vec%0d", i), 32'(act()), 32'(tbl[i].exp));
      end
      cmd_we_i = 1'b0;
      mtr_ack_i = 1'b0;

      // fill: one entry leaves for the motor, eight fill the queue
      for (int k = 0; k < 10; k++) begin
         cmd_we_i = 1'b1;
         cmd_pos_i = 8'(10 + k);
         step();
         if (k == 8) begin
            chk("full_flag", 32'(cmd_full_o), 32'd1);
            chk("full_level", 32'(level_o), 32'd8);
         end
         if (k == 9) begin
            chk("full_err", 32'(cmd_err_o), 32'd1);
            chk("full_keep", 32'(level_o), 32'd8);
         end
      end
      cmd_we_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wait_valid($sformatf("order_valid%0d", i));
         chk($sformatf("order_pos%0d", i), 32'(mtr_pos_o), 32'(10 + i));
         ack_once($sformatf("order_ack%0d", i));
      end
      repeat (3) step();
      chk("drain_valid", 32'(mtr_valid_o), 32'd0);
      chk("drain_busy", 32'(busy_o), 32'd0);

      // timeout then resume
      wr(8'd55);
      wait_valid("tmo_start");
      repeat (TMO - 1) step();
      chk("tmo_last_valid", 32'(mtr_valid_o), 32'd1);
      step();
      chk("tmo_state", 32'({mtr_valid_o, tmo_o, mtr_pos_o}),
          32'({1'b0, 1'b1, 8'd55}));
      wr(8'd66);
      chk("halt_accepts", 32'({level_o, mtr_valid_o}), 32'({4'd1, 1'b0}));
      clr_tmo_i = 1'b1;
      step();
      clr_tmo_i = 1'b0;
      chk("tmo_resume", 32'({mtr_valid_o, tmo_o, mtr_pos_o}),
          32'({1'b1, 1'b0, 8'd55}));
      ack_once("tmo_ack");
      wait_valid("after_tmo_valid");
      chk("after_tmo_pos", 32'(mtr_pos_o), 32'd66);
      ack_once("after_tmo_ack");

      // ack in the very cycle the timeout would fire
      wr(8'd77);
      wait_valid("edge_start");
      repeat (TMO - 1) step();
      mtr_ack_i = 1'b1;
      step();
      mtr_ack_i = 1'b0;
      chk("edge_ack_wins", 32'({mtr_valid_o, tmo_o}), 32'd0);
      step();
      chk("edge_idle", 32'(busy_o), 32'd0);

      // flush with one in flight, plus a write dropped by the flush
      for (int k = 0; k < 4; k++) wr(8'(1 + k));
      chk("pre_flush", 32'({level_o, mtr_valid_o, mtr_pos_o}),
          32'({4'd3, 1'b1, 8'd1}));
      cmd_we_i = 1'b1;
      cmd_pos_i = 8'd9;
      flush_i = 1'b1;
      step();
      cmd_we_i = 1'b0;
      flush_i = 1'b0;
      chk("flush_state",
          32'({level_o, mtr_valid_o, mtr_pos_o, cmd_err_o}),
          32'({4'd0, 1'b1, 8'd1, 1'b0}));
      ack_once("flush_ack");
      repeat (4) step();
      chk("flush_no_more", 32'({mtr_valid_o, busy_o}), 32'd0);

      // async reset mid-handshake
      for (int k = 0; k < 5; k++) wr(8'(20 + k));
      chk("pre_reset", 32'({level_o, mtr_valid_o}), 32'({4'd4, 1'b1}));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_reset", 32'({mtr_valid_o, level_o, tmo_o, busy_o}), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      chk("post_reset", 32'({mtr_valid_o, busy_o}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
